serial_borrow_counter: RTL and testbench

SERIAL_BORROW_COUNTER -- requirements
Module: serial_borrow_counter

---
 rtl/serial_borrow_counter_pkg.sv | 12 +
 rtl/serial_borrow_counter_borrow_stage.sv | 36 +++
 rtl/serial_borrow_counter.sv | 67 ++++++
 tb/tb_serial_borrow_counter.sv | 119 +++++++++++
 4 files changed

// File: rtl/serial_borrow_counter_pkg.sv
// Shared definitions for the serial borrow-chain down counter:
// the count-mode encodings and the default counter width.
package serial_borrow_counter_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   typedef enum logic {
      MODE_WRAP    = 1'b0,
      MODE_ONESHOT = 1'b1
   } mode_e;

endpackage : serial_borrow_counter_pkg

// File: rtl/serial_borrow_counter_borrow_stage.sv
// One bit of the borrow-chain down counter: a toggle flop with a parallel load.
// It resets to 1 and passes the borrow on only while its own bit is 0.
module borrow_stage (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic d,
   input  logic t,
   output logic q,
   output logic b_out
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = d;
      end else if (t) begin
         q_d = ~q_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= 1'b1;
      end else begin
         q_q <= q_d;
      end
   end

   assign q     = q_q;
   assign b_out = t & ~q_q;

endmodule : borrow_stage

// File: rtl/serial_borrow_counter.sv
// Down counter built as a ripple borrow chain of per-bit toggle stages, with
// parallel load, wrap or one-shot mode, terminal borrow and a sticky done flag.
module serial_borrow_counter
   import serial_borrow_counter_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             mode,
   output logic [WIDTH-1:0] out,
   output logic             borrow_out,
   output logic             done
);

   logic [WIDTH:0] borrow;
   logic           zero;
   logic           oneshot;
   logic           en_eff;
   logic           done_q;
   logic           done_d;

   assign zero    = (out == '0);
   assign oneshot = (mode_e'(mode) == MODE_ONESHOT);

   // In one-shot mode the chain is frozen at zero so the count parks there.
   assign en_eff    = en & ~load & ~(oneshot & zero);
   assign borrow[0] = en_eff;

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      borrow_stage u_stage (
         .clk   (clk),
         .reset (reset),
         .load  (load),
         .d     (din[i]),
         .t     (borrow[i]),
         .q     (out[i]),
         .b_out (borrow[i+1])
      );
   end

   always_comb begin
      done_d = done_q;
      if (load) begin
         done_d = 1'b0;
      end else if (en && oneshot && (out <= WIDTH'(1))) begin
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
      end
   end

   assign done = done_q;

   // The chain's end borrow covers wrap mode; the frozen one-shot case is added back.
   assign borrow_out = ~reset & (borrow[WIDTH] | (en & ~load & oneshot & zero));

endmodule : serial_borrow_counter

// File: tb/tb_serial_borrow_counter.sv
// Self-checking bench: directed scenarios plus random stimulus against an
// arithmetic reference model of the down counter.
module tb_serial_borrow_counter;

   localparam int unsigned W   = 4;
   localparam int unsigned MAX = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         en = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] din = '0;
   logic         mode = 1'b0;
   logic [W-1:0] out;
   logic         borrow_out;
   logic         done;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   int unsigned m_out  = 0;
   bit          m_done = 1'b0;

   serial_borrow_counter #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .load       (load),
      .din        (din),
      .mode       (mode),
      .out        (out),
      .borrow_out (borrow_out),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive at negedge, check combinational borrow, advance the model,
   // then check registered outputs just after the rising edge.
   task automatic step(input bit r, input bit l, input bit e, input bit m,
                       input int unsigned d, input string tag);
      bit exp_b;
      @(negedge clk);
      reset = r; load = l; en = e; mode = m; din = W'(d);
      #1;
      exp_b = !r && !l && e && (m_out == 0);
      check({tag, "_borrow"}, {31'd0, borrow_out}, {31'd0, exp_b});
      if (r) begin
         m_out = MAX; m_done = 1'b0;
      end else if (l) begin
         m_out = d & MAX; m_done = 1'b0;
      end else if (e) begin
         if (!m) begin
            m_out = (m_out + MAX) % (MAX + 1);
         end else begin
            if (m_out <= 1) m_done = 1'b1;
            if (m_out > 0) m_out = m_out - 1;
         end
      end
      @(posedge clk);
      #1;
      check({tag, "_out"}, {28'd0, out}, m_out);
      check({tag, "_done"}, {31'd0, done}, {31'd0, m_done});
   endtask

   initial begin
      // Reset state, then a full wrap-mode sweep through zero.
      step(1, 0, 0, 0, 0, "rst");
      check("rst_out_lit", {28'd0, out}, 32'd15);
      for (int i = 0; i < 17; i++) step(0, 0, 1, 0, 0, "wrap");
      check("wrap_end_lit", {28'd0, out}, 32'd14);

      // One-shot from 3 down to zero and parked there.
      step(0, 1, 0, 1, 3, "ld3");
      for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, "oneshot");
      check("oneshot_end_lit", {28'd0, out}, 32'd0);

      // Switch to wrap while done: wraps, done sticks until load.
      step(0, 0, 1, 0, 0, "wrap_done");
      check("wrap_done_lit", {31'd0, done}, 32'd1);
      step(0, 0, 1, 1, 0, "md_chg");
      step(0, 1, 0, 0, 2, "ld2");

      // Load beats enable on the same edge.
      step(0, 1, 1, 0, 9, "ld_en");
      check("ld_en_lit", {28'd0, out}, 32'd9);

      // Reset mid-count with load and enable asserted.
      step(0, 1, 0, 0, 5, "ld5");
      step(1, 1, 1, 0, 7, "rst_mid");
      // Reset while done is set.
      step(0, 1, 0, 1, 1, "ld1");
      step(0, 0, 1, 1, 0, "to_zero");
      step(1, 0, 1, 1, 0, "rst_done");

      // Hold with enable low.
      step(0, 1, 0, 0, 6, "ld6");
      for (int i = 0; i < 4; i++) step(0, 0, 0, i[0], 0, "hold");
      check("hold_lit", {28'd0, out}, 32'd6);

      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
              $urandom_range(0, MAX), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_serial_borrow_counter
